// File: rtl/move_step_ctrl.sv
// Push-button front end for the X/Y duty datapath: debounce, per-axis step/auto-repeat
// scheduling and saturating duty registers feeding the PWM stage.
module move_step_ctrl #(
    parameter int DUTY_W        = 6,
    parameter int STEP          = 4,
    parameter int DUTY_MAX      = 60,
    parameter int DB_CYCLES     = 50000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic              sysclk,
    input  logic              Reset_Sw,
    input  logic              Bt_Up,
    input  logic              Bt_Down,
    input  logic              Bt_Left,
    input  logic              Bt_Right,
    output logic [DUTY_W-1:0] DC_X,
    output logic [DUTY_W-1:0] DC_Y,
    output logic              Step_X,
    output logic              Step_Y,
    output logic              Lim_X,
    output logic              Lim_Y
);

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [DUTY_W:0]  STEP_EXT    = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W:0]  MAX_EXT     = (DUTY_W + 1)'(DUTY_MAX);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} axis_state_t;

    // Button index: 0 Right (X+), 1 Left (X-), 2 Up (Y+), 3 Down (Y-)
    logic [3:0]      btn_raw;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      deb;
    logic [DB_W-1:0] db_cnt [4];

    logic [1:0]        pos_btn;
    logic [1:0]        neg_btn;
    axis_state_t       state    [2];
    axis_state_t       state_nx [2];
    logic [TMR_W-1:0]  tmr      [2];
    logic [TMR_W-1:0]  tmr_nx   [2];
    logic [DUTY_W-1:0] dc       [2];
    logic [DUTY_W-1:0] dc_nx    [2];
    logic [1:0]        dir;
    logic [1:0]        dir_nx;
    logic [1:0]        step_q;
    logic [1:0]        step_nx;

    assign btn_raw = {Bt_Down, Bt_Up, Bt_Left, Bt_Right};
    assign pos_btn = {deb[2], deb[0]};
    assign neg_btn = {deb[3], deb[1]};

    // Extended by one bit so neither direction can wrap before clamping
    function automatic logic [DUTY_W-1:0] step_duty(input logic [DUTY_W-1:0] cur,
                                                    input logic up);
        logic [DUTY_W:0] ext;
        logic [DUTY_W:0] wide;
        ext  = {1'b0, cur};
        wide = up ? (ext + STEP_EXT) : (ext - STEP_EXT);
        if (up && (wide > MAX_EXT))
            return MAX_EXT[DUTY_W-1:0];
        if (!up && (ext < STEP_EXT))
            return '0;
        return wide[DUTY_W-1:0];
    endfunction

    always_ff @(posedge sysclk or posedge Reset_Sw) begin
        if (Reset_Sw) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 4; i++)
                db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= ~deb[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge sysclk or posedge Reset_Sw) begin
        if (Reset_Sw) begin
            dir    <= '0;
            step_q <= '0;
            for (int a = 0; a < 2; a++) begin
                state[a] <= IDLE;
                tmr[a]   <= '0;
                dc[a]    <= '0;
            end
        end else begin
            dir    <= dir_nx;
            step_q <= step_nx;
            for (int a = 0; a < 2; a++) begin
                state[a] <= state_nx[a];
                tmr[a]   <= tmr_nx[a];
                dc[a]    <= dc_nx[a];
            end
        end
    end

    // dir records which button owns the axis while in HOLD/REPEAT (1 = pos)
    always_comb begin
        dir_nx  = dir;
        step_nx = '0;
        for (int a = 0; a < 2; a++) begin
            state_nx[a] = state[a];
            tmr_nx[a]   = (tmr[a] == '0) ? '0 : (tmr[a] - 1'b1);
            dc_nx[a]    = dc[a];
            case (state[a])
                IDLE: begin
                    if (pos_btn[a] && neg_btn[a]) begin
                        state_nx[a] = LOCK;
                    end else if (pos_btn[a] || neg_btn[a]) begin
                        step_nx[a]  = 1'b1;
                        dir_nx[a]   = pos_btn[a];
                        tmr_nx[a]   = HOLD_LOAD;
                        state_nx[a] = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (dir[a] ? neg_btn[a] : pos_btn[a]) begin
                        state_nx[a] = LOCK;
                    end else if (!(dir[a] ? pos_btn[a] : neg_btn[a])) begin
                        state_nx[a] = IDLE;
                    end else if (tmr[a] == '0) begin
                        step_nx[a]  = 1'b1;
                        tmr_nx[a]   = REPEAT_LOAD;
                        state_nx[a] = REPEAT;
                    end
                end
                LOCK: begin
                    if (!pos_btn[a] && !neg_btn[a])
                        state_nx[a] = IDLE;
                end
                default: state_nx[a] = IDLE;
            endcase
            if (step_nx[a])
                dc_nx[a] = step_duty(dc[a], dir_nx[a]);
        end
    end

    assign DC_X   = dc[0];
    assign DC_Y   = dc[1];
    assign Step_X = step_q[0];
    assign Step_Y = step_q[1];
    assign Lim_X  = (dc[0] == '0) || (dc[0] == MAX_EXT[DUTY_W-1:0]);
    assign Lim_Y  = (dc[1] == '0) || (dc[1] == MAX_EXT[DUTY_W-1:0]);

endmodule

// File: tb/tb_move_step_ctrl.sv
// Directed bench for move_step_ctrl with short debounce/hold/repeat times and
// hand-computed duty values; inputs driven and outputs sampled on the falling edge.
module tb_move_step_ctrl;

    logic       sysclk;
    logic       Reset_Sw;
    logic       Bt_Up;
    logic       Bt_Down;
    logic       Bt_Left;
    logic       Bt_Right;
    logic [5:0] DC_X;
    logic [5:0] DC_Y;
    logic       Step_X;
    logic       Step_Y;
    logic       Lim_X;
    logic       Lim_Y;

    int checks;
    int errors;
    int step_x_cnt;
    int step_y_cnt;
    int base_cnt;

    move_step_ctrl #(
        .DUTY_W(6), .STEP(4), .DUTY_MAX(60),
        .DB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
    ) dut (
        .sysclk(sysclk), .Reset_Sw(Reset_Sw),
        .Bt_Up(Bt_Up), .Bt_Down(Bt_Down), .Bt_Left(Bt_Left), .Bt_Right(Bt_Right),
        .DC_X(DC_X), .DC_Y(DC_Y), .Step_X(Step_X), .Step_Y(Step_Y),
        .Lim_X(Lim_X), .Lim_Y(Lim_Y)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    always @(negedge sysclk) begin
        if (Step_X) step_x_cnt++;
        if (Step_Y) step_y_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic applyStimulus(input logic right, input logic left,
                                 input logic up, input logic down);
        Bt_Right = right;
        Bt_Left  = left;
        Bt_Up    = up;
        Bt_Down  = down;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        applyStimulus(0, 0, 0, 0);
        Reset_Sw = 1'b1;
        tick(2);
        Reset_Sw = 1'b0;
        tick(2);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        step_x_cnt = 0;
        step_y_cnt = 0;
        Reset_Sw   = 1'b1;
        applyStimulus(0, 0, 0, 0);
        tick(2);
        checkOutput("rst_dcx", DC_X, 0);
        checkOutput("rst_dcy", DC_Y, 0);
        checkOutput("rst_stepx", Step_X, 0);
        checkOutput("rst_stepy", Step_Y, 0);
        checkOutput("rst_limx", Lim_X, 1);
        checkOutput("rst_limy", Lim_Y, 1);
        Reset_Sw = 1'b0;
        tick(2);

        $display("[TB] single press");
        base_cnt = step_x_cnt;
        applyStimulus(1, 0, 0, 0);
        tick(6);
        checkOutput("t1_before", DC_X, 0);
        tick(1);
        checkOutput("t1_dcx", DC_X, 4);
        checkOutput("t1_stepx", Step_X, 1);
        tick(1);
        checkOutput("t1_pulse_end", Step_X, 0);
        tick(12);
        applyStimulus(0, 0, 0, 0);
        tick(20);
        checkOutput("t1_count", step_x_cnt - base_cnt, 1);
        checkOutput("t1_dcx_hold", DC_X, 4);
        checkOutput("t1_dcy", DC_Y, 0);

        $display("[TB] bounce then hold");
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0);
            tick(2);
            applyStimulus(0, 0, 0, 0);
            tick(2);
        end
        tick(2);
        checkOutput("t2_bounce_steps", step_y_cnt, 0);
        checkOutput("t2_bounce_dcy", DC_Y, 0);
        applyStimulus(0, 0, 1, 0);
        tick(7);
        checkOutput("t2_first", DC_Y, 4);
        tick(19);
        checkOutput("t2_wait_hold", DC_Y, 4);
        tick(1);
        checkOutput("t2_second", DC_Y, 8);
        checkOutput("t2_second_step", Step_Y, 1);
        tick(8);
        checkOutput("t2_third", DC_Y, 12);
        tick(5);
        applyStimulus(0, 0, 0, 0);
        tick(10);

        $display("[TB] saturation up and down");
        resetDut();
        applyStimulus(1, 0, 0, 0);
        tick(7);
        checkOutput("t3_up1", DC_X, 4);
        tick(20);
        checkOutput("t3_up2", DC_X, 8);
        tick(96);
        checkOutput("t3_up14", DC_X, 56);
        checkOutput("t3_lim_off", Lim_X, 0);
        tick(8);
        checkOutput("t3_sat", DC_X, 60);
        checkOutput("t3_lim_hi", Lim_X, 1);
        tick(69);
        base_cnt = step_x_cnt;
        tick(100);
        checkOutput("t3_more_steps", int'(step_x_cnt > base_cnt), 1);
        checkOutput("t3_still_sat", DC_X, 60);
        applyStimulus(0, 0, 0, 0);
        tick(20);
        applyStimulus(0, 1, 0, 0);
        tick(7);
        checkOutput("t3_dn1", DC_X, 56);
        tick(20);
        checkOutput("t3_dn2", DC_X, 52);
        tick(96);
        checkOutput("t3_dn14", DC_X, 4);
        tick(8);
        checkOutput("t3_zero", DC_X, 0);
        checkOutput("t3_lim_lo", Lim_X, 1);
        tick(69);
        checkOutput("t3_no_wrap", DC_X, 0);
        applyStimulus(0, 0, 0, 0);
        tick(20);

        $display("[TB] opposing buttons");
        resetDut();
        base_cnt = step_x_cnt;
        applyStimulus(1, 1, 0, 0);
        tick(40);
        checkOutput("t4_lock_steps", step_x_cnt - base_cnt, 0);
        applyStimulus(0, 1, 0, 0);
        tick(40);
        checkOutput("t4_one_left_steps", step_x_cnt - base_cnt, 0);
        applyStimulus(0, 0, 0, 0);
        tick(20);
        applyStimulus(0, 1, 0, 0);
        tick(7);
        checkOutput("t4_step_at_zero", Step_X, 1);
        checkOutput("t4_dcx", DC_X, 0);
        applyStimulus(0, 0, 0, 0);
        tick(20);

        $display("[TB] reset during repeat");
        resetDut();
        applyStimulus(0, 0, 1, 0);
        tick(43);
        checkOutput("t5_dcy16", DC_Y, 16);
        tick(3);
        #2 Reset_Sw = 1'b1;
        #1;
        checkOutput("t5_async_dcy", DC_Y, 0);
        checkOutput("t5_async_step", Step_Y, 0);
        tick(2);
        Reset_Sw = 1'b0;
        tick(6);
        checkOutput("t5_after_before", DC_Y, 0);
        tick(1);
        checkOutput("t5_after_dcy", DC_Y, 4);
        checkOutput("t5_after_step", Step_Y, 1);
        applyStimulus(0, 0, 0, 0);
        tick(10);

        $display("[TB] simultaneous axes");
        resetDut();
        applyStimulus(1, 0, 1, 0);
        tick(7);
        checkOutput("t6_stepx", Step_X, 1);
        checkOutput("t6_stepy", Step_Y, 1);
        checkOutput("t6_dcx", DC_X, 4);
        checkOutput("t6_dcy", DC_Y, 4);
        applyStimulus(0, 0, 0, 0);
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
